// File: rtl/average_wrap.sv
// average_wrap
//   AXI-Lite CSR slave (32 x 32-bit registers) plus a read-only 512-bit AXI
//   master. A GO rising edge fetches COUNT 32-bit words from {ADDR_HI,ADDR_LO}
//   (64-byte aligned), sums them in 64 bits and leaves the truncated average
//   in RESULT.
// Ports
//   clock, reset            : rising-edge clock, async active-high reset
//   axil_aw/w/b/ar/r_*      : AXI-Lite CSR slave
//   axi_aw/w/b_*            : write master (unused, held idle)
//   axi_ar_* / axi_r_*      : read master, packed AR/R payload buses
module average_wrap #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    axil_aw_valid,
  output logic                    axil_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   axil_aw_addr,
  input  logic                    axil_w_valid,
  output logic                    axil_w_ready,
  input  logic [DATA_WIDTH-1:0]   axil_w_data,
  input  logic [DATA_WIDTH/8-1:0] axil_w_strb,
  output logic                    axil_b_valid,
  input  logic                    axil_b_ready,
  output logic [1:0]              axil_b_resp,
  input  logic                    axil_ar_valid,
  output logic                    axil_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   axil_ar_addr,
  output logic                    axil_r_valid,
  input  logic                    axil_r_ready,
  output logic [DATA_WIDTH-1:0]   axil_r_data,
  output logic [1:0]              axil_r_resp,
  output logic [108:0]            axi_aw_data,
  output logic                    axi_aw_valid,
  input  logic                    axi_aw_ready,
  output logic [576:0]            axi_w_data,
  output logic                    axi_w_valid,
  input  logic                    axi_w_ready,
  input  logic [17:0]             axi_b_data,
  input  logic                    axi_b_valid,
  output logic                    axi_b_ready,
  output logic [108:0]            axi_ar_data,
  output logic                    axi_ar_valid,
  input  logic                    axi_ar_ready,
  input  logic [530:0]            axi_r_data,
  input  logic                    axi_r_valid,
  output logic                    axi_r_ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_DIV  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // AXI-Lite slave state
  logic                    r_aw_got, r_w_got, r_bvalid, r_rvalid;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;

  // CSRs
  logic [31:0] r_go, r_count, r_addr_lo, r_addr_hi, r_result;
  logic [31:0] r_scratch [32];
  logic        r_started, r_done, r_err;

  // Engine
  logic [2:0]   r_state;
  logic [31:0]  r_run_count, r_remain, r_rem;
  logic [63:0]  r_beat_addr, r_sum;
  logic [511:0] r_beat;
  logic [3:0]   r_lane;
  logic [5:0]   r_div_cnt;

  logic        w_wr_en, w_wr_ok, w_clear, w_ge;
  logic [4:0]  w_wr_idx, w_rd_idx;
  logic [31:0] w_rd_data, w_lane;
  logic [32:0] w_rem_shift, w_rem_sub;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int unsigned b = 0; b < 4; b++)
      if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  assign w_wr_en  = r_aw_got && r_w_got && !r_bvalid;
  assign w_wr_idx = r_awaddr[6:2];
  assign w_wr_ok  = (r_awaddr[ADDR_WIDTH-1:7] == '0);
  assign w_clear  = w_wr_en && w_wr_ok && (w_wr_idx == 5'd2) && r_wstrb[0] && r_wdata[0];
  assign w_rd_idx = axil_ar_addr[6:2];

  always_comb begin
    w_rd_data = '0;
    if (axil_ar_addr[ADDR_WIDTH-1:7] == '0) begin
      case (w_rd_idx)
        5'd0:    w_rd_data = r_go;
        5'd1:    w_rd_data = {31'b0, r_started};
        5'd2:    w_rd_data = '0;
        5'd3:    w_rd_data = {30'b0, r_err, r_done};
        5'd4:    w_rd_data = r_count;
        5'd5:    w_rd_data = r_addr_lo;
        5'd6:    w_rd_data = r_addr_hi;
        5'd7:    w_rd_data = r_result;
        default: w_rd_data = r_scratch[w_rd_idx];
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_go      <= '0;
      r_count   <= '0;
      r_addr_lo <= '0;
      r_addr_hi <= '0;
      for (int unsigned i = 0; i < 32; i++) r_scratch[i] <= '0;
    end else begin
      if (axil_aw_valid && !r_aw_got) begin
        r_aw_got <= 1'b1;
        r_awaddr <= axil_aw_addr;
      end
      if (axil_w_valid && !r_w_got) begin
        r_w_got <= 1'b1;
        r_wdata <= axil_w_data;
        r_wstrb <= axil_w_strb;
      end
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        if (w_wr_ok) begin
          case (w_wr_idx)
            5'd0:    r_go      <= merge(r_go, r_wdata, r_wstrb);
            5'd4:    r_count   <= merge(r_count, r_wdata, r_wstrb);
            5'd5:    r_addr_lo <= merge(r_addr_lo, r_wdata, r_wstrb);
            5'd6:    r_addr_hi <= merge(r_addr_hi, r_wdata, r_wstrb);
            default: if (w_wr_idx >= 5'd8)
                       r_scratch[w_wr_idx] <= merge(r_scratch[w_wr_idx], r_wdata, r_wstrb);
          endcase
        end
      end
      if (r_bvalid && axil_b_ready) begin
        r_bvalid <= 1'b0;
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end
      if (axil_ar_valid && !r_rvalid) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (r_rvalid && axil_r_ready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign w_lane      = r_beat[{r_lane, 5'd0} +: 32];
  // Restoring division: r_sum doubles as the dividend/quotient shift register.
  assign w_rem_shift = {r_rem, r_sum[63]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_run_count});
  assign w_rem_sub   = w_rem_shift - {1'b0, r_run_count};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_started   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_result    <= '0;
      r_run_count <= '0;
      r_remain    <= '0;
      r_rem       <= '0;
      r_beat_addr <= '0;
      r_sum       <= '0;
      r_beat      <= '0;
      r_lane      <= '0;
      r_div_cnt   <= '0;
    end else begin
      if (!r_go[0]) r_started <= 1'b0;
      if (w_clear) begin
        r_done  <= 1'b0;
        r_err   <= 1'b0;
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (r_go[0] && !r_started && !r_done) begin
            r_run_count <= r_count;
            r_remain    <= r_count;
            r_beat_addr <= {r_addr_hi, r_addr_lo[31:6], 6'b0};
            r_sum       <= '0;
            r_started   <= 1'b1;
            if (r_count == 32'd0) begin
              r_result <= '0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_AR;
            end
          end
          S_AR: if (axi_ar_ready) r_state <= S_R;
          S_R: if (axi_r_valid) begin
            r_beat  <= axi_r_data[514:3];
            if (axi_r_data[2:1] != 2'b00) r_err <= 1'b1;
            r_lane  <= '0;
            r_state <= S_ACC;
          end
          S_ACC: begin
            r_sum    <= r_sum + {32'b0, w_lane};
            r_remain <= r_remain - 32'd1;
            if (r_remain == 32'd1) begin
              r_rem     <= '0;
              r_div_cnt <= '0;
              r_state   <= S_DIV;
            end else if (r_lane == 4'd15) begin
              r_beat_addr <= r_beat_addr + 64'd64;
              r_state     <= S_AR;
            end else begin
              r_lane <= r_lane + 4'd1;
            end
          end
          S_DIV: begin
            r_rem     <= w_ge ? w_rem_sub[31:0] : w_rem_shift[31:0];
            r_sum     <= {r_sum[62:0], w_ge};
            r_div_cnt <= r_div_cnt + 6'd1;
            if (r_div_cnt == 6'd63) begin
              r_result <= {r_sum[30:0], w_ge};
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          S_DONE:  ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign axil_aw_ready = !r_aw_got;
  assign axil_w_ready  = !r_w_got;
  assign axil_b_valid  = r_bvalid;
  assign axil_b_resp   = 2'b00;
  assign axil_ar_ready = !r_rvalid;
  assign axil_r_valid  = r_rvalid;
  assign axil_r_data   = r_rdata;
  assign axil_r_resp   = 2'b00;

  assign axi_aw_data  = '0;
  assign axi_aw_valid = 1'b0;
  assign axi_w_data   = '0;
  assign axi_w_valid  = 1'b0;
  assign axi_b_ready  = 1'b1;

  // ID 0, LEN 0, SIZE 6 (64 B), BURST INCR; payload zero while idle
  assign axi_ar_valid = (r_state == S_AR);
  assign axi_ar_data  = axi_ar_valid ?
                        {16'd0, r_beat_addr, 8'd0, 3'd6, 2'b01, 1'b0, 4'd0, 3'd0, 8'd0} : '0;
  assign axi_r_ready  = (r_state == S_R);

  logic w_unused;
  assign w_unused = &{1'b0, axi_aw_ready, axi_w_ready, axi_b_data, axi_b_valid,
                      axi_r_data[530:515], axi_r_data[0], r_awaddr[1:0], axil_ar_addr[1:0]};

endmodule

// File: tb/tb_average_wrap.sv
// tb_average_wrap
//   Directed bench for average_wrap: AXI-Lite host tasks, a single-beat
//   AXI-to-SRAM read bridge, an arithmetic model of the averaging job and a
//   per-cycle monitor checking every AR beat and the idle write master.
module tb_average_wrap;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         axil_aw_valid = 1'b0, axil_aw_ready;
  logic [11:0]  axil_aw_addr = '0;
  logic         axil_w_valid = 1'b0, axil_w_ready;
  logic [31:0]  axil_w_data = '0;
  logic [3:0]   axil_w_strb = '0;
  logic         axil_b_valid, axil_b_ready = 1'b0;
  logic [1:0]   axil_b_resp;
  logic         axil_ar_valid = 1'b0, axil_ar_ready;
  logic [11:0]  axil_ar_addr = '0;
  logic         axil_r_valid, axil_r_ready = 1'b0;
  logic [31:0]  axil_r_data;
  logic [1:0]   axil_r_resp;
  logic [108:0] axi_aw_data, axi_ar_data;
  logic         axi_aw_valid, axi_w_valid, axi_b_ready, axi_ar_valid, axi_r_ready;
  logic [576:0] axi_w_data;
  logic [530:0] axi_r_data;

  // SRAM bridge state
  logic [31:0]  mem [0:2047];
  logic         m_ar_ready, m_pend, m_r_valid;
  logic         m_hold_r = 1'b0;
  logic [63:0]  m_addr;
  logic [63:0]  m_err_addr = '1;
  logic [511:0] m_rdata;
  logic [1:0]   m_rresp;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_ar[$];
  logic [31:0] rd;

  always #5 clock = ~clock;

  average_wrap #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .axil_aw_valid(axil_aw_valid), .axil_aw_ready(axil_aw_ready), .axil_aw_addr(axil_aw_addr),
    .axil_w_valid(axil_w_valid), .axil_w_ready(axil_w_ready), .axil_w_data(axil_w_data),
    .axil_w_strb(axil_w_strb),
    .axil_b_valid(axil_b_valid), .axil_b_ready(axil_b_ready), .axil_b_resp(axil_b_resp),
    .axil_ar_valid(axil_ar_valid), .axil_ar_ready(axil_ar_ready), .axil_ar_addr(axil_ar_addr),
    .axil_r_valid(axil_r_valid), .axil_r_ready(axil_r_ready), .axil_r_data(axil_r_data),
    .axil_r_resp(axil_r_resp),
    .axi_aw_data(axi_aw_data), .axi_aw_valid(axi_aw_valid), .axi_aw_ready(1'b0),
    .axi_w_data(axi_w_data), .axi_w_valid(axi_w_valid), .axi_w_ready(1'b0),
    .axi_b_data(18'd0), .axi_b_valid(1'b0), .axi_b_ready(axi_b_ready),
    .axi_ar_data(axi_ar_data), .axi_ar_valid(axi_ar_valid), .axi_ar_ready(m_ar_ready),
    .axi_r_data(axi_r_data), .axi_r_valid(m_r_valid), .axi_r_ready(axi_r_ready)
  );

  assign axi_r_data = {16'd0, m_rdata, m_rresp, 1'b1};

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ar_ready <= 1'b1;
      m_pend     <= 1'b0;
      m_r_valid  <= 1'b0;
      m_addr     <= '0;
      m_rdata    <= '0;
      m_rresp    <= 2'b00;
    end else begin
      if (axi_ar_valid && m_ar_ready) begin
        m_ar_ready <= 1'b0;
        m_pend     <= 1'b1;
        m_addr     <= axi_ar_data[92:29];
      end
      if (m_pend && !m_r_valid && !m_hold_r) begin
        m_r_valid <= 1'b1;
        for (int l = 0; l < 16; l++) m_rdata[32*l +: 32] <= mem[m_addr[12:2] + 11'(l)];
        m_rresp <= (m_addr == m_err_addr) ? 2'd2 : 2'd0;
      end
      if (m_r_valid && axi_r_ready) begin
        m_r_valid  <= 1'b0;
        m_pend     <= 1'b0;
        m_ar_ready <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] align(input logic [63:0] a);
    return {a[63:6], 6'b0};
  endfunction

  function automatic logic [108:0] pack_ar(input logic [63:0] a);
    return {16'd0, a, 8'd0, 3'd6, 2'b01, 1'b0, 4'd0, 3'd0, 8'd0};
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] cnt, input logic [63:0] base);
    logic [63:0] sum;
    logic [10:0] w0;
    sum = '0;
    w0  = align(base) >> 2;
    for (int unsigned k = 0; k < cnt; k++) sum += {32'b0, mem[w0 + 11'(k)]};
    return (cnt == 0) ? 32'd0 : 32'(sum / {32'b0, cnt});
  endfunction

  function automatic logic [31:0] model_status(input logic [31:0] cnt, input logic [63:0] base);
    logic err;
    err = 1'b0;
    for (int unsigned b = 0; b * 16 < cnt; b++)
      if (align(base) + 64'(64 * b) == m_err_addr) err = 1'b1;
    return {30'b0, err, 1'b1};
  endfunction

  task automatic expect_ars(input logic [31:0] cnt, input logic [63:0] base);
    for (int unsigned b = 0; b * 16 < cnt; b++) exp_ar.push_back(align(base) + 64'(64 * b));
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      check("wr_master_idle", {axi_aw_valid, axi_w_valid, axi_b_ready}, 128'b001);
      if (axi_ar_valid) begin
        if (exp_ar.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ar: got addr %h expected no AR", axi_ar_data[92:29]);
        end else begin
          check("ar_beat", axi_ar_data, pack_ar(exp_ar[0]));
          if (m_ar_ready) void'(exp_ar.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: AW and W together, 1: AW first, 2: W first
  task automatic axil_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode);
    int  n;
    logic aw_done, w_done, aw_hs, w_hs;
    n = 0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    axil_aw_addr  = a;
    axil_w_data   = d;
    axil_w_strb   = s;
    axil_aw_valid = (mode != 2);
    axil_w_valid  = (mode != 1);
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = axil_aw_valid && axil_aw_ready;
      w_hs  = axil_w_valid && axil_w_ready;
      tick();
      n++;
      if (aw_hs) begin axil_aw_valid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin axil_w_valid  = 1'b0; w_done  = 1'b1; end
      if (aw_done && !w_done) axil_w_valid = 1'b1;
      if (w_done && !aw_done) axil_aw_valid = 1'b1;
    end
    axil_aw_valid = 1'b0;
    axil_w_valid  = 1'b0;
    n = 0;
    while (!axil_b_valid && n < 50) begin tick(); n++; end
    if (!axil_b_valid) begin
      checks++;
      errors++;
      $display("FAIL bvalid_timeout: addr %h got no bvalid expected bvalid", a);
    end else begin
      check("b_resp", axil_b_resp, 128'd0);
      axil_b_ready = 1'b1;
      tick();
      axil_b_ready = 1'b0;
    end
  endtask

  task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
    int n;
    n = 0;
    d = '0;
    axil_ar_addr  = a;
    axil_ar_valid = 1'b1;
    while (!axil_ar_ready && n < 50) begin tick(); n++; end
    tick();
    axil_ar_valid = 1'b0;
    n = 0;
    while (!axil_r_valid && n < 50) begin tick(); n++; end
    if (!axil_r_valid) begin
      checks++;
      errors++;
      $display("FAIL rvalid_timeout: addr %h got no rvalid expected rvalid", a);
    end else begin
      d = axil_r_data;
      check("r_resp", axil_r_resp, 128'd0);
      axil_r_ready = 1'b1;
      tick();
      axil_r_ready = 1'b0;
    end
  endtask

  task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axil_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_done();
    logic [31:0] s;
    int n;
    s = '0;
    n = 0;
    while (!s[0] && n < 100) begin axil_read(12'h00C, s); n++; end
    if (!s[0]) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: STATUS %h expected DONE bit set", s);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    for (int i = 1024; i < 1044; i++) mem[i] = 32'd7;
    for (int i = 1044; i < 1056; i++) mem[i] = 32'hFFFF_FFFF;
    for (int i = 128; i < 144; i++) mem[i] = 32'(100 + i - 128);

    repeat (3) tick();
    check("rst_lite_ready", {axil_aw_ready, axil_w_ready, axil_ar_ready, axil_b_valid, axil_r_valid},
          128'b11100);
    check("rst_axi_ctrl", {axi_ar_valid, axi_r_ready, axi_b_ready, axi_aw_valid, axi_w_valid},
          128'b00100);
    check("rst_buses", {axi_ar_data, axil_r_data}, 128'd0);
    check("rst_wbus", axi_w_data, '0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) read_check("rst_csr", 12'(4 * i), 32'd0);

    for (int i = 8; i < 32; i++) axil_write(12'(4 * i), 32'(i), 4'hF, i % 3);
    for (int i = 8; i < 32; i++) read_check("scratch", 12'(4 * i), 32'(i));
    axil_write(12'h024, 32'hAABB_CCDD, 4'b0101, 0);
    read_check("strb_merge", 12'h024, 32'h00BB_00DD);
    axil_write(12'h008, 32'd1, 4'hF, 0);
    read_check("clear_reads0", 12'h008, 32'd0);
    axil_write(12'h820, 32'hDEAD_BEEF, 4'hF, 0);
    read_check("hi_addr_wr_ignored", 12'h020, 32'd8);
    read_check("hi_addr_rd0", 12'h800, 32'd0);
    axil_write(12'h01C, 32'h1234, 4'hF, 0);
    read_check("result_ro", 12'h01C, 32'd0);

    // 32 words 0..31 at base 0
    check("model_pin_a", model_result(32, 64'h0), 32'd15);
    axil_write(12'h010, 32'd32, 4'hF, 0);
    axil_write(12'h014, 32'h0, 4'hF, 0);
    axil_write(12'h018, 32'h0, 4'hF, 0);
    expect_ars(32, 64'h0);
    axil_write(12'h000, 32'd1, 4'hF, 1);
    wait_done();
    read_check("status_a", 12'h00C, model_status(32, 64'h0));
    read_check("result_a", 12'h01C, model_result(32, 64'h0));
    read_check("started_a", 12'h004, 32'd1);
    check("ars_done_a", exp_ar.size(), 128'd0);
    axil_write(12'h000, 32'd0, 4'hF, 0);
    axil_write(12'h008, 32'd1, 4'hF, 0);
    read_check("status_clr_a", 12'h00C, 32'd0);
    read_check("started_clr_a", 12'h004, 32'd0);

    // 20 sevens at 0x1000 (low bits of ADDR_LO dropped); COUNT rewritten mid-run
    check("model_pin_b", model_result(20, 64'h1013), 32'd7);
    axil_write(12'h010, 32'd20, 4'hF, 0);
    axil_write(12'h014, 32'h1013, 4'hF, 2);
    expect_ars(20, 64'h1013);
    axil_write(12'h000, 32'd1, 4'hF, 0);
    axil_write(12'h010, 32'd5, 4'hF, 0);
    wait_done();
    read_check("result_b", 12'h01C, model_result(20, 64'h1013));
    read_check("status_b", 12'h00C, 32'd1);
    read_check("addr_lo_rb", 12'h014, 32'h1013);
    check("ars_done_b", exp_ar.size(), 128'd0);
    axil_write(12'h000, 32'd0, 4'hF, 0);
    axil_write(12'h008, 32'd1, 4'hF, 0);

    // COUNT = 0: no fetch, immediate DONE
    axil_write(12'h010, 32'd0, 4'hF, 0);
    axil_write(12'h000, 32'd1, 4'hF, 0);
    wait_done();
    read_check("status_c", 12'h00C, 32'd1);
    read_check("result_c", 12'h01C, 32'd0);
    axil_write(12'h008, 32'd1, 4'hF, 0);
    read_check("status_clr_c", 12'h00C, 32'd0);

    // One beat at 0x5_0000_0200 answered with SLVERR
    m_err_addr = 64'h5_0000_0200;
    check("model_pin_d", model_result(16, 64'h5_0000_0200), 32'd107);
    axil_write(12'h010, 32'd16, 4'hF, 0);
    axil_write(12'h014, 32'h200, 4'hF, 0);
    axil_write(12'h018, 32'h5, 4'hF, 0);
    expect_ars(16, 64'h5_0000_0200);
    axil_write(12'h000, 32'd0, 4'hF, 0);
    axil_write(12'h000, 32'd1, 4'hF, 0);
    wait_done();
    read_check("status_err", 12'h00C, model_status(16, 64'h5_0000_0200));
    read_check("result_d", 12'h01C, model_result(16, 64'h5_0000_0200));
    axil_write(12'h008, 32'd1, 4'hF, 0);
    repeat (20) tick();
    read_check("no_restart_status", 12'h00C, 32'd0);
    read_check("no_restart_started", 12'h004, 32'd1);
    m_err_addr = '1;
    expect_ars(16, 64'h5_0000_0200);
    axil_write(12'h000, 32'd0, 4'hF, 0);
    read_check("started_go0", 12'h004, 32'd0);
    axil_write(12'h000, 32'd1, 4'hF, 0);
    wait_done();
    read_check("status_restart", 12'h00C, model_status(16, 64'h5_0000_0200));
    read_check("result_restart", 12'h01C, 32'd107);

    // Reset while waiting for read data
    m_hold_r = 1'b1;
    axil_write(12'h008, 32'd1, 4'hF, 0);
    axil_write(12'h018, 32'h0, 4'hF, 0);
    axil_write(12'h014, 32'h0, 4'hF, 0);
    expect_ars(16, 64'h0);
    axil_write(12'h000, 32'd0, 4'hF, 0);
    axil_write(12'h000, 32'd1, 4'hF, 0);
    begin
      int n;
      n = 0;
      while (!axi_r_ready && n < 100) begin tick(); n++; end
      check("reached_r_state", axi_r_ready, 128'd1);
    end
    reset = 1'b1;
    #1;
    check("rst_mid_ctrl", {axi_ar_valid, axi_r_ready}, 128'b00);
    tick();
    check("rst_mid_next", {axi_ar_valid, axi_r_ready, axil_r_data}, 128'd0);
    reset    = 1'b0;
    m_hold_r = 1'b0;
    exp_ar.delete();
    tick();
    for (int i = 0; i < 8; i++) read_check("rst_mid_csr", 12'(4 * i), 32'd0);
    read_check("rst_mid_scratch", 12'h020, 32'd0);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running expected completion");
    $fatal(1, "timeout");
  end

endmodule
